// File: rtl/otter_fetch_pkg.sv
// Shared types and helpers for the OTTER instruction-fetch queue.
package otter_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push/pop, synchronous flush and
// asynchronous reset; DEPTH must be a power of two so the pointers wrap freely.
module fetch_fifo
  import otter_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = count_width(DEPTH)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr_i,
  input  logic         push_i,
  input  fetch_entry_t din_i,
  input  logic         pop_i,
  output fetch_entry_t dout_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q > 0.
  always_ff @(posedge CLK) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER fetch stage: owns fetch PC, issues to 1-cycle-latency imem, queues {pc,ir}
// for decode. Optional FETCH_BYPASS_EN forwards a response straight to decode.
module otter_fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_rden,
  output logic [13:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        de_valid,
  output logic [31:0] de_ir,
  output logic [31:0] de_pc,
  input  logic        de_ready
);

  localparam int unsigned CW = count_width(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_tag_q, pc_tag_d;
  logic          inflight_q, inflight_d;

  logic [31:0]   redirect_tgt;
  logic          pop, issue, can_issue;
  logic [CW:0]   occupancy;
  logic          fifo_push, fifo_pop;
  fetch_entry_t  fifo_din, fifo_dout, head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr_i   (redirect_valid),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    fifo_din.pc = pc_tag_q;
    fifo_din.ir = imem_rdata;
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass    = fifo_empty && inflight_q && !redirect_valid;
    head      = bypass ? fifo_din : fifo_dout;
    de_valid  = !redirect_valid && (!fifo_empty || inflight_q);
    pop       = de_valid && de_ready;
    // A bypassed response accepted this cycle never enters the queue.
    fifo_push = inflight_q && !redirect_valid && !(bypass && de_ready);
    fifo_pop  = pop && !bypass;
  end
`else
  always_comb begin
    head      = fifo_dout;
    de_valid  = !redirect_valid && !fifo_empty;
    pop       = de_valid && de_ready;
    fifo_push = inflight_q && !redirect_valid;
    fifo_pop  = pop;
  end
`endif

  always_comb begin
    de_ir = de_valid ? head.ir : '0;
    de_pc = de_valid ? head.pc : '0;
  end

  // Reserve a slot for every outstanding request so a response always fits.
  always_comb begin
    redirect_tgt = redirect_pc & ~32'h3;
    occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    can_issue    = occupancy < (CW+1)'(DEPTH);
    issue        = !RESET && (redirect_valid || can_issue);
    imem_rden    = issue;
    imem_addr    = redirect_valid ? redirect_tgt[15:2] : fetch_pc_q[15:2];

    fetch_pc_d = fetch_pc_q;
    pc_tag_d   = pc_tag_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_tag_d   = redirect_tgt;
      fetch_pc_d = redirect_tgt + 32'd4;
    end else if (issue) begin
      pc_tag_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_q <= RESET_PC;
      pc_tag_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_tag_q   <= pc_tag_d;
      inflight_q <= inflight_d;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue; honours FETCH_BYPASS_EN for latency.
module tb_otter_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_rden;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        de_valid;
  logic [31:0] de_ir;
  logic [31:0] de_pc;
  logic        de_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rden      (imem_rden),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .de_valid       (de_valid),
    .de_ir          (de_ir),
    .de_pc          (de_pc),
    .de_ready       (de_ready)
  );

  always #5 CLK = ~CLK;

  // Memory word i holds 0x100 + i, one-cycle read latency.
  always @(posedge CLK) begin
    if (imem_rden) imem_rdata <= 32'h100 + {18'd0, imem_addr};
  end

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'h100 + {18'd0, pc[15:2]};
  endfunction

  // Returns at a negedge with RESET still high; caller releases it.
  task automatic hold_reset();
    @(negedge CLK);
    RESET = 1'b1;
    redirect_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    de_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (imem_rden !== 1'b0) begin n_bad++; $display("FAIL reset_rden: got %b want 0", imem_rden); end
    n_cmp++; if (de_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", de_valid); end
    n_cmp++; if (de_ir !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h want 0", de_ir); end
    n_cmp++; if (de_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", de_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    RESET = 1'b0;
    de_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge CLK);
      #1;
      epc = 32'(4 * (c - LAT));
      n_cmp++; if (imem_rden !== 1'b1) begin n_bad++; $display("FAIL stream_rden c%0d: got %b want 1", c, imem_rden); end
      n_cmp++; if (imem_addr !== 14'(c)) begin n_bad++; $display("FAIL stream_addr c%0d: got %h want %h", c, imem_addr, 14'(c)); end
      n_cmp++; if (de_valid !== (c >= LAT)) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, de_valid, c >= LAT); end
      if (c >= LAT) begin
        n_cmp++; if (de_pc !== epc) begin n_bad++; $display("FAIL stream_pc c%0d: got %h want %h", c, de_pc, epc); end
        n_cmp++; if (de_ir !== ir_of(epc)) begin n_bad++; $display("FAIL stream_ir c%0d: got %h want %h", c, de_ir, ir_of(epc)); end
      end
    end
  endtask

  task automatic test_stall();
    int reqs;
    hold_reset();
    RESET = 1'b0;
    de_ready = 1'b0;
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge CLK);
      #1;
      if (imem_rden) reqs++;
      if (c >= LAT) begin
        n_cmp++; if (de_pc !== 32'h0 || de_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold c%0d: got v=%b pc=%h want v=1 pc=0", c, de_valid, de_pc); end
      end
    end
    n_cmp++; if (reqs !== 4) begin n_bad++; $display("FAIL stall_reqs: got %0d want 4", reqs); end
    n_cmp++; if (imem_rden !== 1'b0) begin n_bad++; $display("FAIL stall_rden: got %b want 0", imem_rden); end
    @(negedge CLK);
    de_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge CLK);
      #1;
      n_cmp++; if (de_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid k%0d: got %b want 1", k, de_valid); end
      n_cmp++; if (de_pc !== 32'(4 * k)) begin n_bad++; $display("FAIL drain_pc k%0d: got %h want %h", k, de_pc, 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] epc;
    hold_reset();
    RESET = 1'b0;
    de_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge CLK);
      #1;
    end
    @(negedge CLK);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    de_ready = 1'b1;
    #1;
    n_cmp++; if (de_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid: got %b want 0", de_valid); end
    n_cmp++; if (imem_rden !== 1'b1) begin n_bad++; $display("FAIL redir_rden: got %b want 1", imem_rden); end
    n_cmp++; if (imem_addr !== 14'h80) begin n_bad++; $display("FAIL redir_addr: got %h want 0080", imem_addr); end
    for (int k = 1; k < 6; k++) begin
      @(negedge CLK);
      redirect_valid = 1'b0;
      #1;
      epc = 32'h200 + 32'(4 * (k - LAT));
      n_cmp++; if (de_valid !== (k >= LAT)) begin n_bad++; $display("FAIL redir_after_valid k%0d: got %b want %b", k, de_valid, k >= LAT); end
      if (k >= LAT) begin
        n_cmp++; if (de_pc !== epc) begin n_bad++; $display("FAIL redir_pc k%0d: got %h want %h", k, de_pc, epc); end
        n_cmp++; if (de_ir !== ir_of(epc)) begin n_bad++; $display("FAIL redir_ir k%0d: got %h want %h", k, de_ir, ir_of(epc)); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] epc;
    @(negedge CLK);
    de_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (imem_addr !== 14'h3FFF) begin n_bad++; $display("FAIL wrap_addr0: got %h want 3fff", imem_addr); end
    for (int k = 1; k < 5; k++) begin
      @(negedge CLK);
      redirect_valid = 1'b0;
      #1;
      if (k == 1) begin
        n_cmp++; if (imem_addr !== 14'h0000 || imem_rden !== 1'b1) begin n_bad++; $display("FAIL wrap_addr1: got rden=%b addr=%h want rden=1 addr=0000", imem_rden, imem_addr); end
      end
      epc = 32'hFFFF_FFFC + 32'(4 * (k - LAT));
      if (k >= LAT) begin
        n_cmp++; if (de_pc !== epc) begin n_bad++; $display("FAIL wrap_pc k%0d: got %h want %h", k, de_pc, epc); end
        n_cmp++; if (de_ir !== ir_of(epc)) begin n_bad++; $display("FAIL wrap_ir k%0d: got %h want %h", k, de_ir, ir_of(epc)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    hold_reset();
    RESET = 1'b0;
    de_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge CLK);
      #1;
    end
    n_cmp++; if (de_valid !== 1'b1 || de_pc !== 32'h0) begin n_bad++; $display("FAIL full_before_reset: got v=%b pc=%h want v=1 pc=0", de_valid, de_pc); end
    n_cmp++; if (imem_rden !== 1'b0) begin n_bad++; $display("FAIL full_rden: got %b want 0", imem_rden); end
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    n_cmp++; if (de_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", de_valid); end
    n_cmp++; if (de_ir !== 32'h0) begin n_bad++; $display("FAIL async_ir: got %h want 0", de_ir); end
    n_cmp++; if (de_pc !== 32'h0) begin n_bad++; $display("FAIL async_pc: got %h want 0", de_pc); end
    n_cmp++; if (imem_rden !== 1'b0) begin n_bad++; $display("FAIL async_rden: got %b want 0", imem_rden); end
    @(negedge CLK);
    RESET = 1'b0;
    de_ready = 1'b1;
    #1;
    n_cmp++; if (imem_rden !== 1'b1 || imem_addr !== 14'h0) begin n_bad++; $display("FAIL restart_addr: got rden=%b addr=%h want rden=1 addr=0000", imem_rden, imem_addr); end
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      #1;
      n_cmp++; if (de_valid !== (k >= LAT)) begin n_bad++; $display("FAIL restart_valid k%0d: got %b want %b", k, de_valid, k >= LAT); end
      if (k >= LAT) begin
        n_cmp++; if (de_pc !== 32'(4 * (k - LAT))) begin n_bad++; $display("FAIL restart_pc k%0d: got %h want %h", k, de_pc, 32'(4 * (k - LAT))); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/otter_fetch_queue.md
# otter_fetch_queue

Instruction-fetch stage for the pipelined OTTER core. Owns the fetch PC and drives the instruction port of the OTTER memory, which has a 1-cycle read latency. Returned instructions are buffered together with their PCs in a small queue, and the queue feeds the decode stage through a valid/ready handshake. Stalls are decoupled from memory latency, and redirects from execute (taken branch, JAL, JALR) flush everything in flight.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- redirect_valid  in  1  execute-stage redirect (taken branch/jump), single-cycle pulse
- redirect_pc  in  32  redirect target
- imem_rden  out  1  instruction read enable
- imem_addr  out  14  word address (pc[15:2])
- imem_rdata  in  32  instruction data, valid the cycle after imem_rden
- de_valid  out  1  decode-side entry valid
- de_ir  out  32  instruction at queue head; 0 when !de_valid
- de_pc  out  32  PC of de_ir; 0 when !de_valid
- de_ready  in  1  decode accepts (low = stall)

## Operation
- State:
  - fetch_pc (32)
  - inflight flag plus its pc_tag (32)
  - circular queue of {pc, ir} with rd/wr pointers and a count register of clog2(DEPTH)+1 bits
- Pop: occurs when de_valid && de_ready.
- Issue (normal): imem_rden=1, imem_addr=fetch_pc[15:2] when count + inflight − pop < DEPTH and redirect_valid=0. At the edge: pc_tag<=fetch_pc, fetch_pc<=fetch_pc+4, inflight<=1; otherwise inflight<=0.
- Response: when inflight=1, imem_rdata is pushed as {pc_tag, imem_rdata}. Space is guaranteed by the issue rule, so no overflow is possible.
- Redirect (redirect_valid=1), all in the same cycle:
  - queue cleared (pointers, count = 0)
  - current response discarded
  - de_valid forced 0, so no pop
  - issue proceeds unconditionally with imem_addr=redirect_pc[15:2]; pc_tag<=redirect_pc & ~3, fetch_pc<=(redirect_pc & ~3)+4, inflight<=1
- Arithmetic: fetch_pc increments mod 2^32; imem_addr wraps with pc[15:2]. redirect_pc[1:0] is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into a full queue cannot occur.
- Reset (asynchronous, any time including mid-fetch):
  - fetch_pc=RESET_PC, queue empty, inflight=0
  - de_valid=0, de_ir=0, de_pc=0
  - imem_rden=0 while RESET is high
  - fetch resumes at RESET_PC in the first cycle after deassertion

## Timing
- Without bypass:
  - request in cycle n → data on imem_rdata in n+1 → written at end of n+1 → de_valid in n+2
  - redirect in cycle r → target instruction presented in r+2
- Steady state with de_ready=1: one instruction per cycle.
- Stall: with de_ready=0 for k cycles, de_ir/de_pc hold constant. Fetch continues until count+inflight reaches DEPTH, then imem_rden=0.
- de_valid, de_ir, de_pc come from queue registers (no combinational path from imem_rdata) unless the bypass is compiled in.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and a response arrives, {pc_tag, imem_rdata} drives de_* combinationally in the same cycle (de_valid=1).
  - If de_ready=1, the entry is consumed and not written.
  - Latency drops by one cycle: request n → de_valid n+1; redirect r → target in r+1.
  - Redirect still forces de_valid=0 in cycle r.
- Undefined: all outputs registered, as in Timing.

## Structure
- Package otter_fetch_pkg:
  - fetch_entry_t (packed {pc[31:0], ir[31:0]})
  - NOP_INSTR constant (32'h0000_0013) for bench use
  - clog2-based count width function
- Sub-module fetch_fifo: parameterised circular buffer with push, pop, and synchronous clear (used for redirect flush), plus async reset and count/empty/full outputs.
- Top level: fetch_pc, inflight tracking, issue rule, bypass mux.

## Test plan
- Reset release, RESET_PC=0, de_ready=1, memory word i = 0x100+i:
  - imem_addr 0,1,2… on consecutive cycles
  - de_valid first in cycle 2, de_pc 0,4,8…, de_ir 0x100,0x101,…
- DEPTH=4, de_ready=0 from cycle 0:
  - exactly 4 requests issued, then imem_rden=0
  - de_pc holds 0
  - de_ready raised → de_pc 0,4,8,12,16 back-to-back with no bubble
- Redirect to 0x0000_0203 while queue holds 3 entries and one request is in flight:
  - de_valid=0 that cycle
  - imem_addr=0x80
  - next de_pc=0x200, followed by 0x204
  - no stale PC ever appears
- fetch_pc=0xFFFF_FFFC → next request uses fetch_pc 0x0000_0000; imem_addr wraps 0x3FFF→0x0000.
- RESET asserted mid-stream with queue full → de_valid, de_ir, de_pc all 0 immediately (asynchronous); restart from RESET_PC.
- FETCH_BYPASS_EN defined:
  - request in cycle n → de_valid in n+1 with matching de_ir
  - redirect → target presented at r+1
